// File: rtl/mem_arbiter.sv
// Shares one single-port, word-addressed memory between the instruction-fetch port
// and the load/store port, serving one transaction at a time.
module mem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic       grant;        // 1 = data port owns the current transaction
    logic       last_grant;
    logic       pick_data;
    logic [3:0] wmask;
    logic [2:0] count;

    // Ties go to the port not served last, or always to data in fixed-priority mode.
    always_comb begin
        pick_data = d_req;
        if (i_req && d_req) begin
            pick_data = ROUND_ROBIN ? !last_grant : 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (i_req || d_req) state_next = ISSUE;
            ISSUE: state_next = (wmask == 4'd0) ? WAIT : DONE;
            WAIT:  if (count == 3'd0) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            wmask      <= 4'd0;
            count      <= 3'd0;
            i_rdata    <= 32'd0;
            d_rdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant      <= pick_data;
                        last_grant <= pick_data;
                        if (pick_data) begin
                            mem_addr  <= d_addr;
                            wmask     <= d_wmask;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr <= i_addr;
                            wmask    <= 4'd0;
                        end
                    end
                end
                ISSUE: begin
                    count <= 3'(MEM_LATENCY - 1);
                end
                WAIT: begin
                    if (count != 3'd0) begin
                        count <= count - 3'd1;
                    end else if (grant) begin
                        d_rdata <= mem_rdata;
                    end else begin
                        i_rdata <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes exist only in ISSUE, so a read strobe and a write mask never overlap.
    assign mem_rstrb = (state == ISSUE) && (wmask == 4'd0);
    assign mem_wmask = (state == ISSUE) ? wmask : 4'd0;
    assign i_done    = (state == DONE) && !grant;
    assign d_done    = (state == DONE) && grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiters side by side: instance 0 round-robin with latency 1, instance 1
// fixed data priority with latency 3; a transaction-timeline model predicts both.
module tb_mem_arbiter;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        i_req     [N];
    logic [31:0] i_addr    [N];
    logic [31:0] i_rdata   [N];
    logic        i_done    [N];
    logic        d_req     [N];
    logic [31:0] d_addr    [N];
    logic [3:0]  d_wmask   [N];
    logic [31:0] d_wdata   [N];
    logic [31:0] d_rdata   [N];
    logic        d_done    [N];
    logic [31:0] mem_addr  [N];
    logic        mem_rstrb [N];
    logic [3:0]  mem_wmask [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit rr_of(input int k);
        return (k == 0);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h0010_0093 : {16'hC0DE, 16'(i)};
    endfunction

    mem_arbiter #(.MEM_LATENCY(1), .ROUND_ROBIN(1'b1)) dut0 (
        .clk(clk), .reset(rst[0]),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_done(i_done[0]),
        .d_req(d_req[0]), .d_addr(d_addr[0]), .d_wmask(d_wmask[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_done(d_done[0]),
        .mem_addr(mem_addr[0]), .mem_rstrb(mem_rstrb[0]), .mem_wmask(mem_wmask[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.MEM_LATENCY(3), .ROUND_ROBIN(1'b0)) dut1 (
        .clk(clk), .reset(rst[1]),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_done(i_done[1]),
        .d_req(d_req[1]), .d_addr(d_addr[1]), .d_wmask(d_wmask[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_done(d_done[1]),
        .mem_addr(mem_addr[1]), .mem_rstrb(mem_rstrb[1]), .mem_wmask(mem_wmask[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Memory: byte-masked writes at the edge, reads through a latency pipeline that
    // carries a poison word whenever no read was strobed.
    logic [31:0] mem  [N][64];
    logic [31:0] pipe [N][8];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (cyc == 0) begin
                for (int i = 0; i < 64; i++) mem[k][i] <= init_word(i);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[k][b])
                        mem[k][mem_addr[k][7:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
            end
            pipe[k][0] <= mem_rstrb[k] ? mem[k][mem_addr[k][7:2]] : 32'hBAD0_BAD0;
            for (int s = 1; s < 8; s++) pipe[k][s] <= pipe[k][s-1];
        end
    end

    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    // Model: a transaction occupies cycles 1..dur after its grant cycle, issuing in
    // cycle 1 and completing in cycle dur (2 for writes, 2+latency for reads).
    bit          m_busy  [N];
    bit          m_win   [N];
    bit          m_write [N];
    bit          m_last  [N];
    int          m_n     [N];
    int          m_dur   [N];
    logic [3:0]  m_mask  [N];
    logic [31:0] m_addr  [N];
    logic [31:0] m_wdata [N];
    logic [31:0] m_ir    [N];
    logic [31:0] m_dr    [N];
    logic [31:0] ref_mem [N][64];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (cyc == 0)
                for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
            if (rst[k]) begin
                m_busy[k] = 1'b0; m_last[k] = 1'b1; m_n[k] = 0; m_dur[k] = 0;
                m_addr[k] = 32'd0; m_wdata[k] = 32'd0; m_ir[k] = 32'd0; m_dr[k] = 32'd0;
                m_write[k] = 1'b0; m_win[k] = 1'b0; m_mask[k] = 4'd0;
            end else if (m_busy[k]) begin
                if (m_n[k] == m_dur[k]) begin
                    m_busy[k] = 1'b0;
                end else begin
                    m_n[k]++;
                    if (m_n[k] == m_dur[k] && !m_write[k]) begin
                        if (m_win[k]) m_dr[k] = ref_mem[k][m_addr[k][7:2]];
                        else          m_ir[k] = ref_mem[k][m_addr[k][7:2]];
                    end
                end
            end else if (i_req[k] || d_req[k]) begin
                if (i_req[k] && d_req[k]) m_win[k] = rr_of(k) ? !m_last[k] : 1'b1;
                else                      m_win[k] = d_req[k];
                m_last[k]  = m_win[k];
                m_busy[k]  = 1'b1;
                m_n[k]     = 1;
                m_addr[k]  = m_win[k] ? d_addr[k] : i_addr[k];
                m_write[k] = m_win[k] && (d_wmask[k] != 4'd0);
                if (m_win[k]) begin
                    m_mask[k]  = d_wmask[k];
                    m_wdata[k] = d_wdata[k];
                end
                m_dur[k] = m_write[k] ? 2 : 2 + lat_of(k);
                if (m_write[k])
                    for (int b = 0; b < 4; b++)
                        if (m_mask[k][b])
                            ref_mem[k][m_addr[k][7:2]][8*b +: 8] = m_wdata[k][8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s[%0d] got=%h exp=%h cyc=%0d", name, k, act, exp, cyc);
        end
    endtask

    logic        e_rstrb, e_idone, e_ddone, e_issue, e_fin;
    logic [3:0]  e_wmask;
    logic [31:0] e_addr, e_wdata, e_ir, e_dr;

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst[k]) begin
                e_rstrb = 1'b0; e_wmask = 4'd0; e_idone = 1'b0; e_ddone = 1'b0;
                e_addr = 32'd0; e_wdata = 32'd0; e_ir = 32'd0; e_dr = 32'd0;
            end else begin
                e_issue = m_busy[k] && (m_n[k] == 1);
                e_fin   = m_busy[k] && (m_n[k] == m_dur[k]);
                e_rstrb = e_issue && !m_write[k];
                e_wmask = (e_issue && m_write[k]) ? m_mask[k] : 4'd0;
                e_idone = e_fin && !m_win[k];
                e_ddone = e_fin && m_win[k];
                e_addr  = m_addr[k];
                e_wdata = m_wdata[k];
                e_ir    = m_ir[k];
                e_dr    = m_dr[k];
            end
            checkOutput("mem_rstrb", k, 32'(mem_rstrb[k]), 32'(e_rstrb));
            checkOutput("mem_wmask", k, 32'(mem_wmask[k]), 32'(e_wmask));
            checkOutput("i_done",    k, 32'(i_done[k]),    32'(e_idone));
            checkOutput("d_done",    k, 32'(d_done[k]),    32'(e_ddone));
            checkOutput("mem_addr",  k, mem_addr[k],  e_addr);
            checkOutput("mem_wdata", k, mem_wdata[k], e_wdata);
            checkOutput("i_rdata",   k, i_rdata[k],   e_ir);
            checkOutput("d_rdata",   k, d_rdata[k],   e_dr);
        end
    end

    function automatic bit probe(input int k, input int which);
        case (which)
            0:       return i_done[k];
            1:       return d_done[k];
            2:       return mem_rstrb[k];
            3:       return mem_wmask[k] != 4'd0;
            default: return i_done[k] || d_done[k];
        endcase
    endfunction

    // which: 0 i_done, 1 d_done, 2 mem_rstrb, 3 write mask, 4 either done
    task automatic waitFor(input int k, input int which, input string name, output int at);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            @(negedge clk);
            if (probe(k, which)) at = cyc;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s[%0d] got=timeout exp=event", name, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulseReset(input int k);
        step(); rst[k] = 1'b1;
        step(); step(); rst[k] = 1'b0;
    endtask

    task automatic applyStimulus(input int k);
        int c0, at, prev;
        int port;
        step(); step(); rst[k] = 1'b0;
        step();
        // Fetch read of word 2
        i_addr[k] = 32'h8; i_req[k] = 1'b1; c0 = cyc;
        waitFor(k, 2, "rstrb", at);
        checkOutput("rstrb_cycle", k, 32'(at - c0), 32'd1);
        checkOutput("issue_addr", k, mem_addr[k], 32'h8);
        waitFor(k, 0, "i_done", at);
        checkOutput("fetch_done_cycle", k, 32'(at - c0), 32'(2 + lat_of(k)));
        checkOutput("fetch_data", k, i_rdata[k], 32'h0010_0093);
        step(); i_req[k] = 1'b0;
        if (k == 0) begin
            // Full-word store then load-back
            d_addr[k] = 32'h40; d_wmask[k] = 4'hF; d_wdata[k] = 32'hDEAD_BEEF;
            d_req[k] = 1'b1; c0 = cyc;
            waitFor(k, 3, "wmask", at);
            checkOutput("wmask_cycle", k, 32'(at - c0), 32'd1);
            checkOutput("wmask_val", k, 32'(mem_wmask[k]), 32'hF);
            checkOutput("wdata_val", k, mem_wdata[k], 32'hDEAD_BEEF);
            waitFor(k, 1, "d_done_wr", at);
            checkOutput("write_done_cycle", k, 32'(at - c0), 32'd2);
            step(); d_wmask[k] = 4'h0; c0 = cyc;
            waitFor(k, 1, "d_done_rd", at);
            checkOutput("readback_cycle", k, 32'(at - c0), 32'd3);
            checkOutput("readback_data", k, d_rdata[k], 32'hDEAD_BEEF);
            step(); d_req[k] = 1'b0;
            pulseReset(k);
        end
        // Both ports requesting reads
        i_addr[k] = 32'h0C; d_addr[k] = 32'h10; d_wmask[k] = 4'h0;
        i_req[k] = 1'b1; d_req[k] = 1'b1;
        prev = -1;
        for (int t = 0; t < 4; t++) begin
            if (k == 1 && t == 3) begin
                step(); d_req[k] = 1'b0;
            end
            waitFor(k, 4, "tie_done", at);
            port = d_done[k] ? 1 : 0;
            if (k == 0) checkOutput("rr_order", k, 32'(port), 32'(t % 2));
            else        checkOutput("prio_order", k, 32'(port), (t < 3) ? 32'd1 : 32'd0);
            if (prev >= 0 && !(k == 1 && t == 3))
                checkOutput("tie_spacing", k, 32'(at - prev), 32'(3 + lat_of(k)));
            prev = at;
        end
        step(); i_req[k] = 1'b0; d_req[k] = 1'b0;
        if (k == 0) begin
            // Reset lands while the read waits for data
            step(); i_addr[k] = 32'h8; i_req[k] = 1'b1;
            waitFor(k, 2, "rstrb_pre_reset", at);
            step(); rst[k] = 1'b1;
            @(negedge clk);
            checkOutput("reset_i_done", k, 32'(i_done[k]), 32'd0);
            checkOutput("reset_i_rdata", k, i_rdata[k], 32'd0);
            checkOutput("reset_mem_addr", k, mem_addr[k], 32'd0);
            step(); step(); rst[k] = 1'b0; c0 = cyc;
            waitFor(k, 0, "i_done_post_reset", at);
            checkOutput("post_reset_cycle", k, 32'(at - c0), 32'd3);
            checkOutput("post_reset_data", k, i_rdata[k], 32'h0010_0093);
            step(); i_req[k] = 1'b0;
        end
        step(); step();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; i_req[k] = 1'b0; d_req[k] = 1'b0;
            i_addr[k] = 32'd0; d_addr[k] = 32'd0; d_wmask[k] = 4'd0; d_wdata[k] = 32'd0;
        end
        fork
            applyStimulus(0);
            applyStimulus(1);
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single-port, word-addressed program/data memory between two requesters: the processor's instruction-fetch port and its load/store port.
- Sits between Processor and Memory in the SOC. It owns the memory strobe, address, write mask and write data, and returns read data and a completion pulse to the granted requester.
- Supports round-robin or fixed data-priority arbitration and a configurable memory read latency.

Parameters:
- MEM_LATENCY, 1, cycles from the edge that samples mem_rstrb to mem_rdata being valid; legal range 1..7.
- ROUND_ROBIN, 1, 1 = alternate on simultaneous requests; 0 = data port always wins ties.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level; held until i_done
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetch read data, valid while i_done=1
- i_done  out  1  one-cycle completion pulse, fetch
- d_req  in  1  data request, level; held until d_done
- d_addr  in  32  data byte address
- d_wmask  in  4  byte write mask; 0 = read
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse, data
- mem_addr  out  32  memory byte address (memory uses [31:2])
- mem_rstrb  out  1  memory read strobe
- mem_wmask  out  4  memory byte write enables
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset (async, immediate):
  - state=IDLE; grant=0 (fetch); last_grant=1 (data), so fetch wins the first tie.
  - mem_addr=0, mem_wdata=0, mem_rstrb=0, mem_wmask=0.
  - i_rdata=d_rdata=0; i_done=d_done=0; wait counter=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: ROUND_ROBIN=1 grants the port not in last_grant. ROUND_ROBIN=0 grants data.
  - On grant: register the granted addr into mem_addr. For a data grant, also register d_wmask and d_wdata. For a fetch grant, wmask is forced to 0. Update last_grant and go to ISSUE.
- ISSUE (exactly one cycle):
  - Read (wmask==0): mem_rstrb=1; load counter with MEM_LATENCY-1; go to WAIT.
  - Write: mem_wmask=registered mask, mem_rstrb=0; go to DONE.
  - mem_rstrb and mem_wmask are decoded from state and are 0 in every other state.
- WAIT:
  - Counter>0: decrement.
  - Counter==0: capture mem_rdata into the granted port's rdata register; go to DONE.
- DONE (one cycle):
  - Granted port's done=1; rdata holds the captured value (write: rdata unchanged); return to IDLE.
  - Requests are not evaluated in DONE. The requester drops req at the edge ending DONE; a req seen high in the following IDLE is a new request.
- Latency, with cycle 0 = IDLE with req high:
  - Read: done in cycle 2+MEM_LATENCY (cycle 3 at default).
  - Write: done in cycle 2.
  - Back-to-back throughput: one transaction per 3+MEM_LATENCY cycles (reads) or 3 cycles (writes).
- The non-granted port sees done=0 and its rdata unchanged throughout; its req stays pending.
- Addresses are registered at grant, so requester-side changes after grant have no effect.
- mem_addr holds its last value in IDLE.
- Reset mid-transaction: the transaction is abandoned with no done pulse; a write already issued in ISSUE stays performed.
- Never assert both done outputs in the same cycle. Never assert mem_rstrb and mem_wmask!=0 together.

Test Plan:
- Reset, then i_req=1 with i_addr=0x8 (MEM[2]=0x00100093):
  - mem_rstrb=1 in cycle 1 only, mem_addr=0x8.
  - i_done=1 in cycle 3 with i_rdata=0x00100093.
  - d_done=0 throughout.
- d_req with d_wmask=4'b1111, d_addr=0x40, d_wdata=0xDEADBEEF:
  - mem_wmask=4'hF and mem_wdata=0xDEADBEEF in cycle 1; d_done in cycle 2.
  - Follow-up data read of 0x40 returns d_rdata=0xDEADBEEF.
- Both req held continuously, ROUND_ROBIN=1, after reset:
  - Grants alternate fetch, data, fetch, data.
  - Done pulses alternate with 4-cycle spacing between consecutive reads.
- Same simultaneous stimulus, ROUND_ROBIN=0:
  - Data granted every time while d_req is held.
  - Fetch is granted only in an IDLE cycle where d_req=0.
- MEM_LATENCY=3, fetch read:
  - mem_rstrb in cycle 1; i_done in cycle 5.
  - i_rdata equals mem_rdata sampled at the end of cycle 4.
- Assert reset during WAIT:
  - Outputs go to reset values in the same cycle; no done pulse.
  - After release, a fresh i_req completes normally with correct data.
